twi_slave: RTL

- I2C target (responder) block: the other end of the TWI master link, so the design can answer a board controller on the same two-wire bus.
- Decodes START/STOP, matches a 7-bit device address and ACKs it.
- First written byte sets a register pointer; later writes and reads go to a local byte-register interface with auto-increment.
- Sits beside the WB peripherals; its register-side port connects to a local register file or bridge.

---
 rtl/twi_slave_pkg.sv | 32 +++
 rtl/twi_slave_sync.sv | 68 ++++++
 rtl/twi_slave.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/twi_slave_pkg.sv
// Shared types and constants for the twi_slave I2C target.
// TWI_SLAVE_GCALL_EN: when defined, the general-call write address is also accepted.
package twi_slave_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    IGNORE
  } state_e;

  localparam logic [6:0] GCALL_ADDR  = 7'h00;
  localparam logic       SDA_DRIVE   = 1'b0;
  localparam logic       SDA_RELEASE = 1'b1;

  // Address byte decode: device address with either R/W, optionally general-call write
  function automatic logic addr_hit(input logic [BYTE_W-1:0] b, input logic [6:0] slv);
`ifdef TWI_SLAVE_GCALL_EN
    return (b[7:1] == slv) || (b == {GCALL_ADDR, 1'b0});
`else
    return (b[7:1] == slv);
`endif
  endfunction

endpackage

// File: rtl/twi_slave_sync.sv
// Bus pin synchronizer with registered SCL edge and START/STOP detection.
module twi_slave_sync (
  input  logic CLK_I,
  input  logic RST_I,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_sync,
  output logic start,
  output logic stop
);

  logic scl_meta_q, scl_meta_d, scl_sync_q, scl_sync_d, scl_hist_q, scl_hist_d;
  logic sda_meta_q, sda_meta_d, sda_sync_q, sda_sync_d, sda_hist_q, sda_hist_d;
  logic scl_rise_q, scl_rise_d, scl_fall_q, scl_fall_d;
  logic start_q, start_d, stop_q, stop_d, sda_out_q, sda_out_d;

  always_comb begin
    scl_meta_d = scl_i;
    scl_sync_d = scl_meta_q;
    scl_hist_d = scl_sync_q;
    sda_meta_d = sda_i;
    sda_sync_d = sda_meta_q;
    sda_hist_d = sda_sync_q;
    scl_rise_d = scl_sync_q & ~scl_hist_q;
    scl_fall_d = ~scl_sync_q & scl_hist_q;
    start_d    = scl_sync_q & scl_hist_q & sda_hist_q & ~sda_sync_q;
    stop_d     = scl_sync_q & scl_hist_q & ~sda_hist_q & sda_sync_q;
    sda_out_d  = sda_sync_q;
  end

  // Reset to the idle-bus level so no edge is seen on reset release
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_hist_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_hist_q <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      sda_out_q  <= 1'b1;
    end else begin
      scl_meta_q <= scl_meta_d;
      scl_sync_q <= scl_sync_d;
      scl_hist_q <= scl_hist_d;
      sda_meta_q <= sda_meta_d;
      sda_sync_q <= sda_sync_d;
      sda_hist_q <= sda_hist_d;
      scl_rise_q <= scl_rise_d;
      scl_fall_q <= scl_fall_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      sda_out_q  <= sda_out_d;
    end
  end

  assign scl_rise = scl_rise_q;
  assign scl_fall = scl_fall_q;
  assign sda_sync = sda_out_q;
  assign start    = start_q;
  assign stop     = stop_q;

endmodule

// File: rtl/twi_slave.sv
// I2C target: address match, register pointer, auto-incrementing byte register port.
// TWI_SLAVE_GCALL_EN (see twi_slave_pkg) additionally accepts general-call writes.
module twi_slave
  import twi_slave_pkg::*;
#(
  parameter logic [6:0]  SLV_ADDR = 7'h3A,
  parameter int unsigned ADR_W    = 4
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             TWI_SCL_I,
  input  logic             TWI_SDA_I,
  output logic             TWI_SDA_OEN,
  output logic             REG_WE,
  output logic             REG_RE,
  output logic [ADR_W-1:0] REG_ADR,
  output logic [7:0]       REG_WDAT,
  input  logic [7:0]       REG_RDAT,
  output logic             BUSY
);

  logic scl_rise, scl_fall, sda_sync, start, stop;

  twi_slave_sync u_sync (
    .CLK_I    (CLK_I),
    .RST_I    (RST_I),
    .scl_i    (TWI_SCL_I),
    .sda_i    (TWI_SDA_I),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .sda_sync (sda_sync),
    .start    (start),
    .stop     (stop)
  );

  state_e             state_q, state_d;
  logic [BYTE_W-1:0]  shift_q, shift_d, reg_wdat_q, reg_wdat_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [ADR_W-1:0]   reg_adr_q, reg_adr_d;
  logic               rw_q, rw_d, first_q, first_d, phase_q, phase_d;
  logic               sda_oen_q, sda_oen_d, busy_q, busy_d;
  logic               reg_we_q, reg_we_d, reg_re_q, reg_re_d;
  logic [BYTE_W-1:0]  shift_in_c;
  logic               byte_done_c;

  assign shift_in_c  = {shift_q[BYTE_W-2:0], sda_sync};
  assign byte_done_c = scl_rise && (bit_cnt_q == CNT_W'(7));

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // phase_q marks the second half of a two-step slot (ACK drive, last read bit, master ACK)
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      state_d = ADDR;
    end else begin
      case (state_q)
        ADDR:     if (byte_done_c) state_d = addr_hit(shift_in_c, SLV_ADDR) ? ADDR_ACK : IGNORE;
        ADDR_ACK: if (scl_fall && phase_q) state_d = rw_q ? RD_BYTE : WR_BYTE;
        WR_BYTE:  if (byte_done_c) state_d = WR_ACK;
        WR_ACK:   if (scl_fall && phase_q) state_d = WR_BYTE;
        RD_BYTE:  if (scl_fall && phase_q) state_d = RD_ACK;
        RD_ACK: begin
          if (scl_rise && sda_sync)      state_d = IGNORE;
          else if (scl_fall && phase_q)  state_d = RD_BYTE;
        end
        IDLE, IGNORE: state_d = state_q;
        default:      state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    reg_adr_d  = reg_adr_q;
    reg_wdat_d = reg_wdat_q;
    rw_d       = rw_q;
    first_d    = first_q;
    phase_d    = phase_q;
    sda_oen_d  = sda_oen_q;
    busy_d     = busy_q;
    reg_we_d   = 1'b0;
    reg_re_d   = 1'b0;

    if (reg_we_q) reg_adr_d = reg_adr_q + ADR_W'(1);
    // Read data arrives the cycle after the strobe; present its MSB right away
    if (reg_re_q) begin
      shift_d   = {REG_RDAT[BYTE_W-2:0], 1'b0};
      sda_oen_d = REG_RDAT[BYTE_W-1];
    end

    case (state_q)
      ADDR, WR_BYTE: begin
        if (scl_rise) begin
          shift_d   = shift_in_c;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (byte_done_c && state_q == ADDR) rw_d = sda_sync;
        end
      end
      ADDR_ACK: begin
        if (scl_fall && !phase_q) begin
          sda_oen_d = SDA_DRIVE;
          busy_d    = 1'b1;
          phase_d   = 1'b1;
        end else if (scl_fall) begin
          sda_oen_d = SDA_RELEASE;
          phase_d   = 1'b0;
          bit_cnt_d = '0;
          first_d   = 1'b1;
          reg_re_d  = rw_q;
        end
      end
      WR_ACK: begin
        if (scl_fall && !phase_q) begin
          sda_oen_d = SDA_DRIVE;
          phase_d   = 1'b1;
          if (first_q) begin
            reg_adr_d = ADR_W'(shift_q);
            first_d   = 1'b0;
          end else begin
            reg_wdat_d = shift_q;
            reg_we_d   = 1'b1;
          end
        end else if (scl_fall) begin
          sda_oen_d = SDA_RELEASE;
          phase_d   = 1'b0;
          bit_cnt_d = '0;
        end
      end
      RD_BYTE: begin
        if (scl_rise) begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(7)) phase_d = 1'b1;
        end else if (scl_fall && phase_q) begin
          sda_oen_d = SDA_RELEASE;
          phase_d   = 1'b0;
        end else if (scl_fall) begin
          sda_oen_d = shift_q[BYTE_W-1];
          shift_d   = {shift_q[BYTE_W-2:0], 1'b0};
        end
      end
      RD_ACK: begin
        if (scl_rise) begin
          reg_adr_d = reg_adr_q + ADR_W'(1);
          phase_d   = ~sda_sync;
        end else if (scl_fall && phase_q) begin
          reg_re_d  = 1'b1;
          phase_d   = 1'b0;
          bit_cnt_d = '0;
        end
      end
      default: ;
    endcase

    if (stop || start) begin
      sda_oen_d = SDA_RELEASE;
      busy_d    = 1'b0;
      phase_d   = 1'b0;
      bit_cnt_d = '0;
      reg_we_d  = 1'b0;
      reg_re_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      reg_adr_q  <= '0;
      reg_wdat_q <= '0;
      rw_q       <= 1'b0;
      first_q    <= 1'b0;
      phase_q    <= 1'b0;
      sda_oen_q  <= SDA_RELEASE;
      busy_q     <= 1'b0;
      reg_we_q   <= 1'b0;
      reg_re_q   <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      reg_adr_q  <= reg_adr_d;
      reg_wdat_q <= reg_wdat_d;
      rw_q       <= rw_d;
      first_q    <= first_d;
      phase_q    <= phase_d;
      sda_oen_q  <= sda_oen_d;
      busy_q     <= busy_d;
      reg_we_q   <= reg_we_d;
      reg_re_q   <= reg_re_d;
    end
  end

  assign TWI_SDA_OEN = sda_oen_q;
  assign REG_WE      = reg_we_q;
  assign REG_RE      = reg_re_q;
  assign REG_ADR     = reg_adr_q;
  assign REG_WDAT    = reg_wdat_q;
  assign BUSY        = busy_q;

endmodule
